// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the round-robin front end of the 4:1 bit mux.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/mux-output bundle: requests and data in, grant/select and the output stage out.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic             out_ready;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic             out;

    modport master (
        output req, din, out_ready,
        input  gnt, sel, out_valid, out
    );

    modport slave (
        input  req, din, out_ready,
        output gnt, sel, out_valid, out
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Cyclic priority encoder: first set request starting at ptr, wrapping modulo N_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer: grants one requester, drives the mux select and
// streams its din bit through a registered valid/ready stage, rotating after MAX_HOLD beats.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   bus
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_q, out_d;

    logic             found;
    logic [SEL_W-1:0] pick_idx;
    logic             stall;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    assign stall = out_valid_q & ~bus.out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (found) begin
                    sel_d      = pick_idx;
                    gnt_d      = N_REQ'(1) << pick_idx;
                    hold_cnt_d = 4'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A stalled beat freezes everything, including the reaction to req.
                if (!stall) begin
                    if (bus.req[sel_q] && (hold_cnt_q < HOLD_LIMIT)) begin
                        out_d       = bus.din[sel_q];
                        out_valid_d = 1'b1;
                        hold_cnt_d  = hold_cnt_q + 4'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        gnt_d       = '0;
                        ptr_d       = sel_q + SEL_W'(1);
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: expected beats queued at stimulus time, popped on handshakes.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    typedef struct packed {
        logic [SEL_W-1:0] idx;
        logic             bit_v;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_chk    = 0;
    int    n_pass   = 0;
    int    beat_cnt = 0;
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic v);
        chk(tag, 32'({bus.gnt, bus.sel, bus.out_valid}), 32'({g, s, v}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int n, input logic b);
        beat_t e;
        e.idx   = SEL_W'(idx);
        e.bit_v = b;
        repeat (n) exp_q.push_back(e);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int target;
        target = beat_cnt + n;
        for (int i = 0; i < budget && beat_cnt < target; i++) tick();
        chk(tag, 32'(beat_cnt), 32'(target));
    endtask

    // Handshake monitor: each accepted beat must match the next queued expectation.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            beat_cnt++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat", 32'({bus.gnt, bus.sel, bus.out}),
                    32'({4'b0001 << e.idx, e.idx, e.bit_v}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.din       = '0;
        bus.out_ready = 1'b1;

        // Reset state and idle behaviour
        #2;
        chk("rst_state", 32'({bus.gnt, bus.sel, bus.out_valid, bus.out}), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("s1_idle", 32'({bus.gnt, bus.out_valid}), 32'(0));
        end
        bus.out_ready = 1'b0;
        bus.req       = 4'b0100;
        tick();
        tick();
        chk_out("s1_pre_rst", 4'b0100, 2'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("s1_async_rst", 32'({bus.gnt, bus.sel, bus.out_valid, bus.out}), 32'(0));
        tick();
        tick();
        bus.req       = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;

        // Single requester: latency, 4-beat burst, 2-cycle gap, re-grant
        bus.din = 4'b0100;
        bus.req = 4'b0100;
        push(2, 8, 1'b1);
        tick();
        chk_out("s2_grant", 4'b0100, 2'd2, 1'b0);
        tick();
        chk_out("s2_first", 4'b0100, 2'd2, 1'b1);
        wait_beats("s2_burst1", 4, 20);
        chk_out("s2_gap1", 4'b0000, 2'd2, 1'b0);
        tick();
        chk_out("s2_gap2", 4'b0100, 2'd2, 1'b0);
        tick();
        chk_out("s2_regrant", 4'b0100, 2'd2, 1'b1);
        wait_beats("s2_burst2", 4, 20);
        bus.req = '0;
        tick();
        tick();
        chk("s2_drain", 32'(exp_q.size()), 32'(0));

        // All four requesting: strict rotation from ptr=0
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        bus.din = 4'b1010;
        bus.req = 4'b1111;
        push(0, 4, 1'b0);
        push(1, 4, 1'b1);
        push(2, 4, 1'b0);
        push(3, 4, 1'b1);
        push(0, 4, 1'b0);
        wait_beats("s3_rotate", 20, 100);
        bus.req = '0;
        chk_out("s3_release", 4'b0000, 2'd0, 1'b0);
        tick();
        tick();
        chk("s3_drain", 32'(exp_q.size()), 32'(0));

        // Stall at beat 2 for 3 cycles; din changes during the stall must not leak
        bus.din = 4'b0010;
        bus.req = 4'b0010;
        push(1, 4, 1'b1);
        wait_beats("s4_beat1", 1, 10);
        bus.out_ready = 1'b0;
        bus.din       = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("s4_frozen", 4'b0010, 2'd1, 1'b1);
            chk("s4_out_frozen", 32'(bus.out), 32'(1));
        end
        bus.out_ready = 1'b1;
        bus.din       = 4'b0010;
        wait_beats("s4_rest", 3, 20);
        chk_out("s4_done", 4'b0000, 2'd1, 1'b0);
        bus.req = '0;
        tick();
        tick();
        chk("s4_drain", 32'(exp_q.size()), 32'(0));

        // Requester drops mid-burst; pointer moves past it
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        bus.din = 4'b1010;
        bus.req = 4'b0010;
        base    = beat_cnt;
        push(1, 2, 1'b1);
        push(3, 4, 1'b1);
        tick();
        tick();
        tick();
        bus.req = 4'b1001;
        tick();
        chk_out("s5_release", 4'b0000, 2'd1, 1'b0);
        chk("s5_two_beats", 32'(beat_cnt - base), 32'(2));
        tick();
        chk_out("s5_grant3", 4'b1000, 2'd3, 1'b0);
        wait_beats("s5_burst3", 4, 20);
        bus.req = '0;
        chk_out("s5_done", 4'b0000, 2'd3, 1'b0);
        tick();
        tick();
        chk("s5_drain", 32'(exp_q.size()), 32'(0));

        // Reset mid-burst: in-flight beat dropped, ptr back to 0
        bus.req = 4'b1111;
        push(0, 4, 1'b0);
        wait_beats("s6_burst0", 4, 20);
        tick();
        tick();
        chk_out("s6_pre_rst", 4'b0010, 2'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("s6_async_rst", 32'({bus.gnt, bus.sel, bus.out_valid, bus.out}), 32'(0));
        chk("s6_drain_pre", 32'(exp_q.size()), 32'(0));
        tick();
        tick();
        push(0, 4, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("s6_first_grant", 4'b0001, 2'd0, 1'b0);
        wait_beats("s6_burst", 4, 20);
        bus.req = '0;
        tick();
        tick();
        chk("s6_drain", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
